// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner
// encoding and the default response timeout.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    localparam int MEM_MAX_WAIT = 16;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-enable generation and store-data lane steering for a
// naturally aligned byte/half/word access.
module mem_lane_steer #(
    parameter int XLEN = 32
) (
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_adr_lo,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN/8-1:0] o_be,
    output logic [XLEN-1:0]   o_wdata
);

    localparam int NB = XLEN / 8;

    logic [NB-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        case (i_size)
            2'd0:    w_mask = NB'(4'b0001);
            2'd1:    w_mask = NB'(4'b0011);
            2'd2:    w_mask = NB'(4'b1111);
            default: w_mask = '0;
        endcase
    end

    assign o_be    = w_mask << i_adr_lo;
    assign o_wdata = i_wdata << {i_adr_lo, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction
// fetch and the LSU, one transaction in flight, with timeout abort.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = MEM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,

    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_adr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    output logic              if_err_o,

    input  logic              lsu_req_i,
    input  logic [XLEN-1:0]   lsu_adr_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_err_o,

    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_d;
    arb_owner_t        r_owner;
    arb_owner_t        last_owner_q;
    logic [XLEN-1:0]   r_adr;
    logic              r_we;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_wdata;
    logic [CW-1:0]     wait_cnt_q;
    logic              drop_q;

    logic              w_if_req;
    logic              w_idle;
    logic              w_grant;
    arb_owner_t        w_win;
    logic              w_timeout;
    logic              w_own_if;
    logic              w_kill;
    logic              w_abort;
    logic              w_rsp;
    logic              w_fire;
    logic              w_mem_req;
    logic [XLEN-1:0]   w_data;
    logic [XLEN/8-1:0] w_be;
    logic [XLEN-1:0]   w_wdata;
    logic              w_unused_size;

    assign w_unused_size = lsu_size_i[2];

    mem_lane_steer #(
        .XLEN (XLEN)
    ) u_steer (
        .i_size   (r_size),
        .i_adr_lo (r_adr[1:0]),
        .i_wdata  (r_wdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata)
    );

    // A flushed fetch never competes for the port.
    assign w_if_req = if_req_i & ~flush_i;
    assign w_idle   = (r_state == IDLE);
    assign w_grant  = w_idle & ~reset & (w_if_req | lsu_req_i);
    assign w_own_if = (r_owner == OWN_IF);

    always_comb begin
        w_win = OWN_IF;
        if (w_if_req && lsu_req_i) begin
            w_win = (last_owner_q == OWN_IF) ? OWN_LSU : OWN_IF;
        end else if (lsu_req_i) begin
            w_win = OWN_LSU;
        end
    end

    assign w_timeout = ~w_idle &
                       (wait_cnt_q == CW'(MAX_WAIT - 1));
    assign w_abort   = (r_state == REQ) & w_own_if & flush_i;
    assign w_kill    = w_own_if & (drop_q | flush_i);
    assign w_rsp     = w_timeout |
                       ((r_state == RESP) & mem_rvalid_i);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_d = REQ;
                end
            end
            REQ: begin
                if (w_timeout || w_abort) begin
                    w_state_d = IDLE;
                end else if (mem_gnt_i) begin
                    w_state_d = RESP;
                end
            end
            RESP: begin
                if (w_rsp) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Dropping mem_req on abort keeps the memory from accepting
    // a request whose response nobody would consume.
    assign w_mem_req = (r_state == REQ) & ~w_timeout &
                       ~w_abort & ~reset;
    assign w_fire    = w_rsp & ~reset;
    assign w_data    = w_timeout ? '0 : mem_rdata_i;

    always_comb begin
        if_gnt_o     = w_grant & (w_win == OWN_IF);
        lsu_gnt_o    = w_grant & (w_win == OWN_LSU);

        mem_req_o    = w_mem_req;
        mem_adr_o    = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        if (w_mem_req) begin
            mem_adr_o   = {r_adr[XLEN-1:2], 2'b00};
            mem_we_o    = r_we;
            mem_be_o    = w_own_if ? '1 : w_be;
            mem_wdata_o = w_wdata;
        end

        if_rvalid_o  = w_fire & w_own_if & ~w_kill;
        if_err_o     = 1'b0;
        if_rdata_o   = '0;
        lsu_rvalid_o = w_fire & ~w_own_if;
        lsu_err_o    = 1'b0;
        lsu_rdata_o  = '0;
        if (if_rvalid_o) begin
            if_err_o   = w_timeout;
            if_rdata_o = w_data;
        end
        if (lsu_rvalid_o) begin
            lsu_err_o   = w_timeout;
            lsu_rdata_o = w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            last_owner_q <= OWN_IF;
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_wdata      <= '0;
            wait_cnt_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_grant) begin
                r_owner      <= w_win;
                last_owner_q <= w_win;
                if (w_win == OWN_LSU) begin
                    r_adr   <= lsu_adr_i;
                    r_we    <= lsu_we_i;
                    r_size  <= lsu_size_i[1:0];
                    r_wdata <= lsu_wdata_i;
                end else begin
                    r_adr   <= if_adr_i;
                    r_we    <= 1'b0;
                    r_size  <= 2'd2;
                    r_wdata <= '0;
                end
            end
            if (w_idle || w_state_d == IDLE) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end
            if (w_state_d == IDLE) begin
                drop_q <= 1'b0;
            end else if (r_state == RESP && w_own_if && flush_i) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAXW = 16;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        if_req;
    logic [31:0] if_adr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        lsu_req, lsu_we;
    logic [31:0] lsu_adr, lsu_wdata;
    logic [2:0]  lsu_size;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.XLEN(32), .MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush),
        .if_req_i     (if_req),
        .if_adr_i     (if_adr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .if_err_o     (if_err),
        .lsu_req_i    (lsu_req),
        .lsu_adr_i    (lsu_adr),
        .lsu_we_i     (lsu_we),
        .lsu_size_i   (lsu_size),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .lsu_err_o    (lsu_err),
        .mem_req_o    (mem_req),
        .mem_adr_o    (mem_adr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one in-flight transaction described by its
    // age since grant and whether memory has accepted it yet.
    bit          m_busy, m_own_lsu, m_we, m_acc, m_drop;
    bit          m_last_lsu;
    int          m_size, m_age;
    logic [31:0] m_adr, m_wd;

    task automatic eval();
        logic        e_ig, e_lg, e_mr, e_we;
        logic        e_ir, e_lr, e_ie, e_le;
        logic [31:0] e_adr, e_wd, e_ird, e_lrd, data;
        logic [3:0]  e_be;
        bit          ifr, win, to, kill, rsp, fin;
        @(negedge clk);
        {e_ig, e_lg, e_mr, e_we, e_ir, e_lr, e_ie, e_le} = '0;
        e_adr = '0; e_wd = '0; e_ird = '0; e_lrd = '0;
        e_be = '0; rsp = 0; fin = 0; to = 0; kill = 0;
        if (reset) begin
            m_busy = 0;
            m_last_lsu = 0;
        end else if (!m_busy) begin
            ifr = if_req && !flush;
            if (ifr || lsu_req) begin
                win = (ifr && lsu_req) ? !m_last_lsu : lsu_req;
                e_ig = !win;
                e_lg = win;
                m_busy = 1; m_own_lsu = win; m_last_lsu = win;
                m_age = 0; m_acc = 0; m_drop = 0;
                m_adr  = win ? lsu_adr : if_adr;
                m_we   = win && lsu_we;
                m_size = win ? int'(lsu_size[1:0]) : 2;
                m_wd   = win ? lsu_wdata : 32'h0;
            end
        end else begin
            m_age++;
            to = (m_age == MAXW);
            kill = !m_own_lsu && (m_drop || flush);
            if (!m_acc) begin
                rsp = to;
                fin = to || (!m_own_lsu && flush);
                if (!fin) begin
                    e_mr  = 1;
                    e_adr = m_adr & ~32'h3;
                    e_we  = m_we;
                    e_be  = m_own_lsu ?
                        4'((((1 << (1 << m_size)) - 1) << m_adr[1:0])) :
                        4'hF;
                    e_wd  = m_wd << (8 * m_adr[1:0]);
                    if (mem_gnt) m_acc = 1;
                end
            end else begin
                rsp = to || mem_rvalid;
                fin = rsp;
                if (!m_own_lsu && flush) m_drop = 1;
            end
            if (rsp && !kill) begin
                data = to ? 32'h0 : mem_rdata;
                if (m_own_lsu) begin
                    e_lr = 1; e_le = to; e_lrd = data;
                end else begin
                    e_ir = 1; e_ie = to; e_ird = data;
                end
            end
            if (fin) m_busy = 0;
        end
        check("if_gnt", 32'(if_gnt), 32'(e_ig));
        check("lsu_gnt", 32'(lsu_gnt), 32'(e_lg));
        check("mem_req", 32'(mem_req), 32'(e_mr));
        check("mem_adr", mem_adr, e_adr);
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_be", 32'(mem_be), 32'(e_be));
        check("mem_wdata", mem_wdata, e_wd);
        check("if_rvalid", 32'(if_rvalid), 32'(e_ir));
        check("if_err", 32'(if_err), 32'(e_ie));
        check("if_rdata", if_rdata, e_ird);
        check("lsu_rvalid", 32'(lsu_rvalid), 32'(e_lr));
        check("lsu_err", 32'(lsu_err), 32'(e_le));
        check("lsu_rdata", lsu_rdata, e_lrd);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle_in();
        {flush, if_req, lsu_req, lsu_we} = '0;
        {mem_gnt, mem_rvalid} = '0;
        if_adr = '0; lsu_adr = '0; lsu_wdata = '0;
        lsu_size = '0; mem_rdata = '0;
    endtask

    initial begin
        int sz;
        idle_in();
        reset = 1'b1;
        step();
        eval();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_if_gnt", 32'(if_gnt), 32'h0);
        adv();
        reset = 1'b0;

        // IF-only fetch at minimum latency
        if_req = 1; if_adr = 32'h100; mem_gnt = 1;
        eval(); check("c0_if_gnt", 32'(if_gnt), 32'h1); adv();
        if_req = 0;
        eval(); check("c1_mem_req", 32'(mem_req), 32'h1);
        check("c1_mem_adr", mem_adr, 32'h100); adv();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        eval(); check("c2_if_rvalid", 32'(if_rvalid), 32'h1);
        check("c2_if_rdata", if_rdata, 32'hDEADBEEF); adv();
        idle_in();

        // Tie after reset: LSU first, then IF
        reset = 1; step(); reset = 0;
        if_req = 1; lsu_req = 1; if_adr = 32'h40; lsu_adr = 32'h80;
        lsu_size = 3'd2; mem_gnt = 1; mem_rvalid = 1;
        eval(); check("tie1_lsu_gnt", 32'(lsu_gnt), 32'h1); adv();
        step(); step();
        eval(); check("tie2_if_gnt", 32'(if_gnt), 32'h1); adv();
        idle_in(); mem_gnt = 1; mem_rvalid = 1;
        step(); step(); idle_in();

        // Store byte at 0x203
        lsu_req = 1; lsu_we = 1; lsu_size = 3'd0;
        lsu_adr = 32'h203; lsu_wdata = 32'hAB;
        step(); idle_in();
        eval();
        check("sb_adr", mem_adr, 32'h200);
        check("sb_be", 32'(mem_be), 32'h8);
        check("sb_wdata", mem_wdata, 32'hAB000000);
        check("sb_we", 32'(mem_we), 32'h1);
        adv();
        mem_gnt = 1; step(); mem_gnt = 0; mem_rvalid = 1; step();
        idle_in();

        // Timeout with mem_gnt held low
        lsu_req = 1; lsu_adr = 32'h300; lsu_size = 3'd2;
        step(); idle_in();
        for (int i = 1; i < MAXW; i++) step();
        eval(); check("to_rvalid", 32'(lsu_rvalid), 32'h1);
        check("to_err", 32'(lsu_err), 32'h1); adv();
        eval(); check("to_req_drop", 32'(mem_req), 32'h0); adv();

        // Flush while IF waits in RESP
        if_req = 1; if_adr = 32'h500; mem_gnt = 1; step();
        if_req = 0; step();
        mem_gnt = 0; flush = 1; step();
        flush = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
        eval(); check("fl_if_rvalid", 32'(if_rvalid), 32'h0); adv();
        idle_in(); lsu_req = 1; lsu_adr = 32'h10; lsu_size = 3'd2;
        eval(); check("fl_lsu_gnt", 32'(lsu_gnt), 32'h1); adv();
        idle_in(); mem_gnt = 1; step(); mem_gnt = 0; mem_rvalid = 1;
        step(); idle_in();

        // Reset while in RESP, then a late response
        if_req = 1; if_adr = 32'h600; mem_gnt = 1; step();
        if_req = 0; step(); mem_gnt = 0;
        reset = 1;
        eval(); check("rr_if_rvalid", 32'(if_rvalid), 32'h0); adv();
        reset = 0; mem_rvalid = 1; mem_rdata = 32'h55;
        eval(); check("late_if_rvalid", 32'(if_rvalid), 32'h0);
        check("late_mem_req", 32'(mem_req), 32'h0); adv();
        idle_in();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            if_req = $urandom_range(0, 1);
            if_adr = $urandom & ~32'h3;
            lsu_req = $urandom_range(0, 1);
            lsu_we  = $urandom_range(0, 1);
            sz = $urandom_range(0, 2);
            lsu_size = 3'(sz);
            lsu_adr = $urandom & ~((32'h1 << sz) - 32'h1);
            lsu_wdata  = $urandom;
            mem_gnt    = ($urandom_range(0, 3) == 0);
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
